ingress_framer: RTL and testbench



---
 rtl/ingress_framer_pkg.sv | 31 +++
 rtl/framer_payload_fifo.sv | 52 +++++
 rtl/ingress_framer.sv | 238 +++++++++++++++++++++++
 tb/tb_ingress_framer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_framer_pkg.sv
// ingress_framer shared constants: FSM encoding and header field layout.
// Default port count / word width come from PORT_NUB_TOTAL / DATA_WIDTH.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package ingress_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  function automatic int hdr_len_w(int dw, int ports);
    return dw - 2 * $clog2(ports);
  endfunction

  function automatic int hdr_dest_lsb(int dw, int ports);
    return dw - $clog2(ports);
  endfunction

  function automatic int hdr_src_lsb(int dw, int ports);
    return hdr_len_w(dw, ports);
  endfunction

endpackage

// File: rtl/framer_payload_fifo.sv
// framer_payload_fifo: synchronous DEPTH x WIDTH FIFO with flush.
// Head word is presented combinationally on rdata.
module framer_payload_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ingress_framer.sv
// ingress_framer: buffers one burst, then emits header + payload words.
// Define INGRESS_FRAMER_CHK_EN to append an XOR trailer word.
module ingress_framer
  import ingress_framer_pkg::*;
#(
  parameter int PORT_NUB   = `PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int WIDTH_SEL = $clog2(PORT_NUB),
  localparam int LEN_W     = DATA_WIDTH - 2 * WIDTH_SEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_SEL-1:0]  in_rx_port,
  input  logic [WIDTH_SEL-1:0]  in_tx_port,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vaild,
  input  logic                  in_done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [WIDTH_SEL-1:0]  out_dest,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int DEST_LSB = hdr_dest_lsb(DATA_WIDTH, PORT_NUB);
  localparam int SRC_LSB  = hdr_src_lsb(DATA_WIDTH, PORT_NUB);

  state_t                state_q, state_d;
  logic [WIDTH_SEL-1:0]  dest_q, dest_d;
  logic [WIDTH_SEL-1:0]  src_q, src_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  ovf_q, ovf_d;
  logic                  skip_q, skip_d;
  logic [7:0]            drop_q, drop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [WIDTH_SEL-1:0]  odest_q, odest_d;
  logic                  busy_q, busy_d;
`ifdef INGRESS_FRAMER_CHK_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

  logic                  push, pop, flush;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_full, fifo_empty;
  logic                  xfer, drain, skip_hit, drop_inc, last;
  logic [DATA_WIDTH-1:0] hdr;

  framer_payload_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .flush (flush),
    .rdata (rd_data),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef INGRESS_FRAMER_CHK_EN
  assign last = 1'b0;
`else
  assign last = fifo_cnt == CW'(1);
`endif

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    src_d    = src_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    odest_d  = odest_q;
`ifdef INGRESS_FRAMER_CHK_EN
    chk_d    = chk_q;
`endif
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    drop_inc = 1'b0;
    hdr      = '0;
    xfer     = valid_q && out_ready;

    // A burst starting mid-drain is dropped whole; its done counts it.
    drain    = state_q == ST_HEADER || state_q == ST_PAYLOAD;
    skip_hit = skip_q || (drain && in_vaild);
    skip_d   = skip_hit;
    if (in_done && skip_hit) begin
      skip_d   = 1'b0;
      drop_inc = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (in_vaild && !skip_q) begin
          dest_d  = in_rx_port;
          src_d   = in_tx_port;
          push    = 1'b1;
          len_d   = LEN_W'(1);
          ovf_d   = 1'b0;
          state_d = in_done ? ST_HEADER : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (in_vaild) begin
          if (fifo_full || ovf_q) begin
            ovf_d = 1'b1;
          end else begin
            push  = 1'b1;
            len_d = len_q + LEN_W'(1);
          end
        end
        if (in_done) begin
          if (ovf_d) begin
            flush    = 1'b1;
            drop_inc = 1'b1;
            ovf_d    = 1'b0;
            len_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          pop     = 1'b1;
          data_d  = rd_data;
          sop_d   = 1'b0;
          eop_d   = last;
`ifdef INGRESS_FRAMER_CHK_EN
          chk_d   = rd_data;
`endif
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          if (eop_q) begin
            valid_d = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
            state_d = ST_IDLE;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = rd_data;
            eop_d   = last;
`ifdef INGRESS_FRAMER_CHK_EN
            chk_d   = chk_q ^ rd_data;
          end else begin
            data_d  = chk_q;
            eop_d   = 1'b1;
`endif
          end
        end
      end
    endcase

    // Header is loaded on the same edge that closes the burst.
    if (state_q != ST_HEADER && state_d == ST_HEADER) begin
      hdr[DEST_LSB +: WIDTH_SEL] = dest_d;
      hdr[SRC_LSB +: WIDTH_SEL]  = src_d;
      hdr[LEN_W-1:0]             = len_d;
      data_d  = hdr;
      valid_d = 1'b1;
      sop_d   = 1'b1;
      eop_d   = 1'b0;
      odest_d = dest_d;
    end

    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    busy_d = state_d != ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      src_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      skip_q  <= 1'b0;
      drop_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      odest_q <= '0;
      busy_q  <= 1'b0;
`ifdef INGRESS_FRAMER_CHK_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      skip_q  <= skip_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      odest_q <= odest_d;
      busy_q  <= busy_d;
`ifdef INGRESS_FRAMER_CHK_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_dest  = odest_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ingress_framer.sv
// Directed bench for ingress_framer (default 8 ports, 16-bit words).
// Trailer checks follow INGRESS_FRAMER_CHK_EN.
module tb_ingress_framer;

`ifdef INGRESS_FRAMER_CHK_EN
  localparam logic LE = 1'b0;
`else
  localparam logic LE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_rx_port;
  logic [2:0]  in_tx_port;
  logic [15:0] in_data;
  logic        in_vaild;
  logic        in_done;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_dest;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ingress_framer dut (
    .clk        (clk),
    .rst        (rst),
    .in_rx_port (in_rx_port),
    .in_tx_port (in_tx_port),
    .in_data    (in_data),
    .in_vaild   (in_vaild),
    .in_done    (in_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_dest   (out_dest),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic word(input string tag, input logic [15:0] d,
                      input logic sop, input logic eop);
    chk({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sop"},   32'(out_sop),   32'(sop));
    chk({tag, ".eop"},   32'(out_eop),   32'(eop));
  endtask

  task automatic burst(input logic [2:0] rx, input logic [2:0] tx,
                       input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      in_vaild   = 1'b1;
      in_rx_port = rx;
      in_tx_port = tx;
      in_data    = base + 16'(i);
      step();
    end
    in_vaild = 1'b0;
    in_data  = '0;
    in_done  = 1'b1;
    step();
    in_done  = 1'b0;
  endtask

  task automatic tail(input string tag, input logic [15:0] trl);
`ifdef INGRESS_FRAMER_CHK_EN
    step();
    word({tag, ".trl"}, trl, 1'b0, 1'b1);
`endif
    step();
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'(1'b0));
    chk({tag, ".idle_busy"},  32'(busy),      32'(1'b0));
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(1'b0));
    chk({tag, ".data"},  32'(out_data),  32'(16'h0));
    chk({tag, ".sop"},   32'(out_sop),   32'(1'b0));
    chk({tag, ".eop"},   32'(out_eop),   32'(1'b0));
    chk({tag, ".dest"},  32'(out_dest),  32'(3'd0));
    chk({tag, ".busy"},  32'(busy),      32'(1'b0));
    chk({tag, ".drop"},  32'(drop_cnt),  32'(8'd0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_rx_port = '0;
    in_tx_port = '0;
    in_data    = '0;
    in_vaild   = 1'b0;
    in_done    = 1'b0;
    out_ready  = 1'b1;
    step();
    step();
    zero_outs("rst");
    rst = 1'b0;

    // basic frame
    burst(3'd5, 3'd2, 4, 16'h0020);
    word("b.hdr", 16'hA804, 1'b1, 1'b0);
    chk("b.dest", 32'(out_dest), 32'(3'd5));
    chk("b.busy", 32'(busy), 32'(1'b1));
    step(); word("b.p0", 16'h0020, 1'b0, 1'b0);
    step(); word("b.p1", 16'h0021, 1'b0, 1'b0);
    step(); word("b.p2", 16'h0022, 1'b0, 1'b0);
    step(); word("b.p3", 16'h0023, 1'b0, LE);
    tail("b", 16'h0000);

    // backpressure on 2nd payload word
    burst(3'd5, 3'd2, 4, 16'h0020);
    word("bp.hdr", 16'hA804, 1'b1, 1'b0);
    step(); word("bp.p0", 16'h0020, 1'b0, 1'b0);
    step(); word("bp.p1", 16'h0021, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); word("bp.hold", 16'h0021, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    step(); word("bp.p2", 16'h0022, 1'b0, 1'b0);
    step(); word("bp.p3", 16'h0023, 1'b0, LE);
    tail("bp", 16'h0000);

    // overflow: 17 beats dropped, then a 1-beat burst
    burst(3'd1, 3'd1, 17, 16'h0100);
    chk("ov.valid", 32'(out_valid), 32'(1'b0));
    chk("ov.drop",  32'(drop_cnt),  32'(8'd1));
    chk("ov.busy",  32'(busy),      32'(1'b0));
    burst(3'd1, 3'd3, 1, 16'h0055);
    word("ov.hdr", 16'h2C01, 1'b1, 1'b0);
    step(); word("ov.p0", 16'h0055, 1'b0, LE);
    tail("ov", 16'h0055);

    // collision: new burst while draining with out_ready low
    do_reset();
    burst(3'd3, 3'd4, 3, 16'h0030);
    word("co.hdr", 16'h7003, 1'b1, 1'b0);
    step(); word("co.p0", 16'h0030, 1'b0, 1'b0);
    out_ready  = 1'b0;
    in_vaild   = 1'b1;
    in_rx_port = 3'd6;
    in_tx_port = 3'd1;
    in_data    = 16'h0099;
    step(); word("co.h0", 16'h0030, 1'b0, 1'b0);
    in_data    = 16'h009A;
    step(); word("co.h1", 16'h0030, 1'b0, 1'b0);
    in_vaild   = 1'b0;
    in_data    = '0;
    in_done    = 1'b1;
    step();
    in_done    = 1'b0;
    word("co.h2", 16'h0030, 1'b0, 1'b0);
    chk("co.drop", 32'(drop_cnt), 32'(8'd1));
    chk("co.dest", 32'(out_dest), 32'(3'd3));
    out_ready  = 1'b1;
    step(); word("co.p1", 16'h0031, 1'b0, 1'b0);
    step(); word("co.p2", 16'h0032, 1'b0, LE);
    tail("co", 16'h0033);
    step();
    chk("co.noghost", 32'(out_valid), 32'(1'b0));

    // stray done in IDLE
    do_reset();
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    chk("sd.valid", 32'(out_valid), 32'(1'b0));
    chk("sd.drop",  32'(drop_cnt),  32'(8'd0));
    chk("sd.busy",  32'(busy),      32'(1'b0));
    step();
    chk("sd.valid2", 32'(out_valid), 32'(1'b0));

    // done together with the last beat
    in_vaild   = 1'b1;
    in_rx_port = 3'd7;
    in_tx_port = 3'd0;
    in_data    = 16'h0070;
    step();
    in_data    = 16'h0071;
    in_done    = 1'b1;
    step();
    in_vaild   = 1'b0;
    in_done    = 1'b0;
    in_data    = '0;
    word("dv.hdr", 16'hE002, 1'b1, 1'b0);
    step(); word("dv.p0", 16'h0070, 1'b0, 1'b0);
    step(); word("dv.p1", 16'h0071, 1'b0, LE);
    tail("dv", 16'h0001);

    // reset mid-drain, then a 2-beat burst
    burst(3'd2, 3'd7, 3, 16'h0040);
    word("rm.hdr", 16'h5C03, 1'b1, 1'b0);
    step(); word("rm.p0", 16'h0040, 1'b0, 1'b0);
    do_reset();
    zero_outs("rm.rst");
    burst(3'd4, 3'd1, 2, 16'h0060);
    word("rm.hdr2", 16'h8402, 1'b1, 1'b0);
    chk("rm.dest", 32'(out_dest), 32'(3'd4));
    step(); word("rm.q0", 16'h0060, 1'b0, 1'b0);
    step(); word("rm.q1", 16'h0061, 1'b0, LE);
    tail("rm", 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
